adaptive_threshold_gen: RTL and testbench

ADAPTIVE_THRESHOLD_GEN -- requirements
Module: adaptive_threshold_gen

---
 rtl/threshold_pkg.sv | 25 ++
 rtl/lum_div4.sv | 72 +++++++
 rtl/adaptive_threshold_gen.sv | 121 ++++++++++++
 tb/tb_adaptive_threshold_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// Shared types and constants for the adaptive binarisation threshold generator.
package threshold_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDivide,
    StDone
  } state_e;

  localparam logic [3:0] THR_DEFAULT     = 4'd8;
  localparam logic [3:0] THR_MIN_DEFAULT = 4'd2;
  localparam logic [3:0] THR_MAX_DEFAULT = 4'd13;

  function automatic logic [3:0] clamp_thr(input logic [3:0] q,
                                           input logic [3:0] lo,
                                           input logic [3:0] hi);
    logic [3:0] r;
    r = q;
    if (q < lo) r = lo;
    if (q > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/lum_div4.sv
// Four-step restoring divider producing a 4-bit quotient, saturated to 15 on overflow.
module lum_div4 #(
  parameter int unsigned DIVIDEND_W = 25,
  parameter int unsigned DIVISOR_W  = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [3:0]            quotient,
  output logic                  done
);

  // Wide enough to hold the dividend and the divisor shifted left by 4.
  localparam int unsigned W = ((DIVIDEND_W > DIVISOR_W + 4) ? DIVIDEND_W : DIVISOR_W + 4) + 1;

  logic [W-1:0] rem_q, div_q;
  logic [3:0]   q_q;
  logic [1:0]   step_q;
  logic         busy_q, ovf_q;

  logic [W-1:0] dividend_ext, divisor_ext, shifted;
  logic         ge;
  logic [3:0]   q_next;

  always_comb begin
    dividend_ext = {{(W - DIVIDEND_W){1'b0}}, dividend};
    divisor_ext  = {{(W - DIVISOR_W){1'b0}}, divisor};
    shifted      = div_q << step_q;
    ge           = (rem_q >= shifted);
    q_next       = ge ? (q_q | (4'(1) << step_q)) : q_q;
    quotient     = ovf_q ? 4'hF : q_next;
    done         = busy_q && (step_q == 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      div_q  <= '0;
      q_q    <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      rem_q  <= '0;
      div_q  <= '0;
      q_q    <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= dividend_ext;
      div_q  <= divisor_ext;
      q_q    <= '0;
      step_q <= 2'd3;
      busy_q <= 1'b1;
      // A quotient of 16 or more cannot be represented in four steps.
      ovf_q  <= (dividend_ext >= (divisor_ext << 4));
    end else if (busy_q) begin
      if (ge) rem_q <= rem_q - shifted;
      q_q <= q_next;
      if (step_q == 2'd0) begin
        busy_q <= 1'b0;
      end else begin
        step_q <= step_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/adaptive_threshold_gen.sv
// Per-frame mean-luminance threshold: accumulates RGB444 pixels, divides by 3*count, clamps.
module adaptive_threshold_gen
  import threshold_pkg::*;
#(
  parameter int unsigned CNT_W   = 19,
  parameter int unsigned SUM_W   = 25,
  parameter logic [3:0]  THR_MIN = THR_MIN_DEFAULT,
  parameter logic [3:0]  THR_MAX = THR_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_start,
  input  logic       i_frame_end,
  input  logic       i_pix_valid,
  input  logic [3:0] i_r,
  input  logic [3:0] i_g,
  input  logic [3:0] i_b,
  output logic [3:0] o_threshold,
  output logic       o_thr_valid,
  output logic       o_busy
);

  localparam int unsigned DIV_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       thr_q, thr_d;

  logic [SUM_W-1:0] base_sum;
  logic [CNT_W-1:0] base_cnt;
  logic [5:0]       lum;
  logic [SUM_W:0]   sum_add;
  logic [DIV_W-1:0] divisor;
  logic             acc_en;
  logic             div_start, div_done;
  logic [3:0]       div_q;

  always_comb begin
    lum      = {2'b00, i_r} + {2'b00, i_g} + {2'b00, i_b};
    // A frame start restarts the accumulators; a coincident pixel is the new frame's first.
    base_sum = i_frame_start ? '0 : sum_q;
    base_cnt = i_frame_start ? '0 : cnt_q;
    acc_en   = i_pix_valid && (i_frame_start || (state_q == StAccum));
    sum_add  = {1'b0, base_sum} + {{(SUM_W - 5){1'b0}}, lum};

    sum_d = base_sum;
    cnt_d = base_cnt;
    if (acc_en && (base_cnt != CNT_MAX)) begin
      cnt_d = base_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
      sum_d = sum_add[SUM_W] ? SUM_MAX : sum_add[SUM_W-1:0];
    end

    divisor = ({2'b00, cnt_d} << 1) + {2'b00, cnt_d};
  end

  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    div_start = 1'b0;
    if (i_frame_start) begin
      state_d = StAccum;
    end else begin
      case (state_q)
        StAccum: begin
          if (i_frame_end) begin
            if (cnt_d == '0) begin
              state_d = StIdle;
            end else begin
              state_d   = StDivide;
              div_start = 1'b1;
            end
          end
        end
        StDivide: begin
          if (div_done) begin
            thr_d   = clamp_thr(div_q, THR_MIN, THR_MAX);
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sum_q   <= '0;
      cnt_q   <= '0;
      thr_q   <= THR_DEFAULT;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
    end
  end

  lum_div4 #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_frame_start),
    .start   (div_start),
    .dividend(sum_d),
    .divisor (divisor),
    .quotient(div_q),
    .done    (div_done)
  );

  assign o_threshold = thr_q;
  assign o_thr_valid = (state_q == StDone);
  assign o_busy      = (state_q == StAccum) || (state_q == StDivide);

endmodule

// File: tb/tb_adaptive_threshold_gen.sv
// Directed bench for adaptive_threshold_gen: frame table plus abort/reset/collision sequences.
module tb_adaptive_threshold_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_frame_start, i_frame_end, i_pix_valid;
  logic [3:0] i_r, i_g, i_b;
  logic [3:0] o_threshold;
  logic       o_thr_valid, o_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adaptive_threshold_gen dut (
    .clk          (clk),
    .reset        (reset),
    .i_frame_start(i_frame_start),
    .i_frame_end  (i_frame_end),
    .i_pix_valid  (i_pix_valid),
    .i_r          (i_r),
    .i_g          (i_g),
    .i_b          (i_b),
    .o_threshold  (o_threshold),
    .o_thr_valid  (o_thr_valid),
    .o_busy       (o_busy)
  );

  typedef struct {
    string      name;
    int         n1;
    logic [3:0] v1;
    int         n2;
    logic [3:0] v2;
    bit         start_pix;
    bit         end_pix;
    logic [3:0] exp_thr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input bit vld, input logic [3:0] v);
    i_pix_valid = vld;
    i_r = v;
    i_g = v;
    i_b = v;
  endtask

  // Called with i_frame_end driven for cycle N; checks cycles N+1..N+6.
  task automatic check_result(input string name, input logic [3:0] exp_thr, input bit exp_pulse);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        i_frame_end = 1'b0;
        set_pix(1'b0, 4'd0);
        check({name, "_busy_div"}, 32'(o_busy), 32'(exp_pulse));
      end
      check($sformatf("%s_valid_c%0d", name, k), 32'(o_thr_valid), 32'(exp_pulse && (k == 5)));
      if (k >= 5) check($sformatf("%s_thr_c%0d", name, k), 32'(o_threshold), 32'(exp_thr));
    end
    check({name, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_frame(input vec_t t);
    logic [3:0] px[$];
    logic [3:0] last;
    // Stray pixel while idle must be ignored.
    set_pix(1'b1, 4'd15);
    step();
    for (int i = 0; i < t.n1; i++) px.push_back(t.v1);
    for (int i = 0; i < t.n2; i++) px.push_back(t.v2);
    last = 4'd0;
    if (t.end_pix) last = px.pop_back();
    i_frame_start = 1'b1;
    if (t.start_pix) set_pix(1'b1, px.pop_front());
    else set_pix(1'b0, 4'd0);
    step();
    i_frame_start = 1'b0;
    check({t.name, "_busy_acc"}, 32'(o_busy), 32'd1);
    while (px.size() > 0) begin
      set_pix(1'b1, px.pop_front());
      step();
    end
    i_frame_end = 1'b1;
    set_pix(t.end_pix, last);
    check_result(t.name, t.exp_thr, 1'b1);
  endtask

  initial begin
    bit pulse_seen;

    vecs[0] = '{"uniform12", 100, 4'd12, 0, 4'd0, 1'b0, 1'b0, 4'd12};
    vecs[1] = '{"split", 50, 4'd15, 50, 4'd0, 1'b0, 1'b0, 4'd7};
    vecs[2] = '{"black", 20, 4'd0, 0, 4'd0, 1'b0, 1'b0, 4'd2};
    vecs[3] = '{"white", 20, 4'd15, 0, 4'd0, 1'b0, 1'b0, 4'd13};
    // 45 / (3*4) = 3; dropping the start pixel gives 2, dropping the end pixel gives 5.
    vecs[4] = '{"edges", 1, 4'd15, 3, 4'd0, 1'b1, 1'b1, 4'd3};

    reset = 1'b1;
    i_frame_start = 1'b0;
    i_frame_end = 1'b0;
    set_pix(1'b0, 4'd0);
    #1;
    check("reset_thr", 32'(o_threshold), 32'd8);
    check("reset_valid", 32'(o_thr_valid), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Empty frame: no pulse, threshold keeps 3.
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    i_frame_end = 1'b1;
    check_result("empty", 4'd3, 1'b0);

    // Abort during divide cycle 2, then a black frame.
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      set_pix(1'b1, 4'd12);
      step();
    end
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    set_pix(1'b0, 4'd0);
    check("abort_busy_div", 32'(o_busy), 32'd1);
    step();
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pix(1'b1, 4'd0);
      step();
      if (o_thr_valid) pulse_seen = 1'b1;
    end
    check("abort_no_pulse", 32'(pulse_seen), 32'd0);
    check("abort_thr_held", 32'(o_threshold), 32'd3);
    i_frame_end = 1'b1;
    set_pix(1'b0, 4'd0);
    check_result("abort_next", 4'd2, 1'b1);

    // Reset mid-frame after an update to 12.
    run_frame(vecs[0]);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_pix(1'b1, 4'd5);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_thr", 32'(o_threshold), 32'd8);
    check("rst_mid_valid", 32'(o_thr_valid), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    set_pix(1'b0, 4'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pix(1'b1, 4'd9);
      step();
    end
    i_frame_end = 1'b1;
    check_result("rst_end_ignored", 4'd8, 1'b0);
    run_frame(vecs[1]);

    // Start and end together: start wins, old frame discarded.
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_pix(1'b1, 4'd15);
      step();
    end
    i_frame_start = 1'b1;
    i_frame_end = 1'b1;
    set_pix(1'b1, 4'd0);
    step();
    i_frame_start = 1'b0;
    i_frame_end = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_pix(1'b1, 4'd0);
      step();
      if (o_thr_valid) pulse_seen = 1'b1;
    end
    check("collide_no_pulse", 32'(pulse_seen), 32'd0);
    check("collide_busy", 32'(o_busy), 32'd1);
    i_frame_end = 1'b1;
    set_pix(1'b0, 4'd0);
    check_result("collide_next", 4'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
